// File: rtl/cdc_hs_pkg.sv
// Shared types and sizing helpers for the req/ack clock-domain-crossing source controller.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_e;

  localparam int CNT_W = 16;

  // Phase counter must be able to hold TIMEOUT_CYC itself (saturation value).
  function automatic int phase_cnt_w(input int timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/cdc_hs_src_ctrl_if.sv
// Upstream word port plus the crossing req/ack/data bus of the handshake source.
interface cdc_hs_src_ctrl_if #(
  parameter int DATA_W = 8
);
  // Upstream valid/ready: a word transfers on a rising clk edge where i_valid && o_ready;
  // o_ready never depends on i_valid, and i_data need only be stable while i_valid is high.
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic              o_xfer_req;
  logic [DATA_W-1:0] o_xfer_data;
  logic              i_xfer_ack;

  modport master (
    output i_data, i_valid, i_xfer_ack,
    input  o_ready, o_xfer_req, o_xfer_data
  );

  modport slave (
    input  i_data, i_valid, i_xfer_ack,
    output o_ready, o_xfer_req, o_xfer_data
  );
endinterface

// File: rtl/cdc_sync_srst.sv
// Single-bit multi-flop synchronizer with synchronous active-high reset.
module cdc_sync_srst #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/cdc_hs_src_ctrl.sv
// Source side of a 4-phase req/ack word crossing: holds the word, sequences req,
// synchronizes ack, counts completed transfers and flags stalled handshake phases.
module cdc_hs_src_ctrl
  import cdc_hs_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  cdc_hs_src_ctrl_if.slave    bus,
  input  logic                i_clr_err,
  output logic                o_busy,
  output logic                o_timeout,
  output logic [CNT_W-1:0]    o_xfer_cnt,
  output state_e              o_state
);

  localparam int PW = phase_cnt_w(TIMEOUT_CYC);
  localparam logic [PW-1:0] C_PHASE_MAX  = PW'(TIMEOUT_CYC);
  localparam logic [PW-1:0] C_PHASE_TRIP = PW'(TIMEOUT_CYC - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                w_ack_s;
  logic                r_xfer_req;
  logic [DATA_W-1:0]   r_xfer_data;
  logic [PW-1:0]       r_phase_cnt;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_xfer_cnt;

  logic                w_ready;
  logic                w_busy;
  logic                w_load;
  logic                w_req_done;
  logic                w_rel_done;
  logic                w_waiting;

  cdc_sync_srst #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.i_xfer_ack),
    .o_q (w_ack_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.i_valid && !w_ack_s) w_state_nxt = REQ;
      REQ:     if (w_ack_s)                 w_state_nxt = REL;
      REL:     if (!w_ack_s)                w_state_nxt = IDLE;
      default:                              w_state_nxt = IDLE;
    endcase
  end

  // A stale high ack left over from a source-only reset keeps IDLE from accepting.
  always_comb begin
    w_ready    = (r_state == IDLE) && !w_ack_s;
    w_busy     = (r_state != IDLE);
    w_load     = w_ready && bus.i_valid;
    w_req_done = (r_state == REQ) && w_ack_s;
    w_rel_done = (r_state == REL) && !w_ack_s;
    w_waiting  = ((r_state == REQ) && !w_ack_s) || ((r_state == REL) && w_ack_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_req  <= 1'b0;
      r_xfer_data <= '0;
    end else if (w_load) begin
      r_xfer_req  <= 1'b1;
      r_xfer_data <= bus.i_data;
    end else if (w_req_done) begin
      r_xfer_req  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase_cnt <= '0;
    end else if (w_load || w_req_done) begin
      r_phase_cnt <= '0;
    end else if (w_busy && (r_phase_cnt != C_PHASE_MAX)) begin
      r_phase_cnt <= r_phase_cnt + 1'b1;
    end
  end

  // Set has priority over a coincident clear so a fresh stall is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else if (w_waiting && (r_phase_cnt == C_PHASE_TRIP)) begin
      r_timeout <= 1'b1;
    end else if (i_clr_err) begin
      r_timeout <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_cnt <= '0;
    end else if (w_rel_done) begin
      r_xfer_cnt <= r_xfer_cnt + 1'b1;
    end
  end

  assign bus.o_ready     = w_ready;
  assign bus.o_xfer_req  = r_xfer_req;
  assign bus.o_xfer_data = r_xfer_data;
  assign o_busy          = w_busy;
  assign o_timeout       = r_timeout;
  assign o_xfer_cnt      = r_xfer_cnt;
  assign o_state         = r_state;

endmodule

// File: tb/tb_cdc_hs_src_ctrl.sv
// Bench for cdc_hs_src_ctrl: directed timing scenarios plus random words, checked by a scoreboard.
module tb_cdc_hs_src_ctrl;
  import cdc_hs_pkg::*;

  localparam int DW = 8;
  localparam int S  = 2;
  localparam int T  = 16;
  localparam int WORD_CYC = 2 * S + 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clr_err = 1'b0;
  logic            busy;
  logic            tmo;
  logic [15:0]     xcnt;
  state_e          st;
  logic            loop_en = 1'b1;
  logic            ack_force = 1'b0;

  int              n_checks = 0;
  int              n_errors = 0;
  int              cyc = 0;
  int              preload_req = 0;

  logic [DW-1:0]   exp_q[$];

  // monitor-owned state
  logic [15:0]     exp_cnt = 16'd0;
  logic [DW-1:0]   cur_data = '0;
  logic            prev_req = 1'b0;
  logic            prev_busy = 1'b0;
  int              preload_seen = 0;

  cdc_hs_src_ctrl_if #(.DATA_W(DW)) bus ();

  assign bus.i_xfer_ack = loop_en ? bus.o_xfer_req : ack_force;

  cdc_hs_src_ctrl #(
    .DATA_W      (DW),
    .SYNC_STAGES (S),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .i_clr_err  (clr_err),
    .o_busy     (busy),
    .o_timeout  (tmo),
    .o_xfer_cnt (xcnt),
    .o_state    (st)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic send(input logic [DW-1:0] d, output int acc_cyc);
    int budget;
    budget = 0;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    while (!bus.o_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.o_ready) begin
      chk("accept_wait_expired", 32'd0, 32'd1);
      bus.i_valid = 1'b0;
      acc_cyc = -1;
    end else begin
      @(posedge clk);
      exp_q.push_back(d);
      #1;
      acc_cyc = cyc;
      bus.i_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    @(posedge clk); #1;
    while (busy && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (busy) chk("idle_wait_expired", 32'd1, 32'd0);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (rst) begin
      exp_cnt   = 16'd0;
      exp_q.delete();
      prev_req  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (preload_req != preload_seen) begin
        exp_cnt      = 16'hFFFF;
        preload_seen = preload_req;
      end
      if (bus.o_xfer_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          cur_data = exp_q.pop_front();
          chk("xfer_data_at_req", 32'(bus.o_xfer_data), 32'(cur_data));
        end
      end else if (busy) begin
        chk("xfer_data_stable", 32'(bus.o_xfer_data), 32'(cur_data));
      end
      if (prev_busy && !busy) begin
        exp_cnt = exp_cnt + 16'd1;
        chk("xfer_cnt_done", 32'(xcnt), 32'(exp_cnt));
      end
      prev_req  = bus.o_xfer_req;
      prev_busy = busy;
    end
  end

  initial begin
    int acc[4];
    int a0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(bus.o_xfer_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(xcnt), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    chk("rst_data", 32'(bus.o_xfer_data), 32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    rst = 1'b0;

    // single word, loopback
    send(8'hA5, a0);
    chk("t1_req_rise", 32'(bus.o_xfer_req), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    edges(2);
    chk("t1_req_e2", 32'(bus.o_xfer_req), 32'd1);
    edges(1);
    chk("t1_req_fall_e3", 32'(bus.o_xfer_req), 32'd0);
    edges(2);
    chk("t1_cnt_e5", 32'(xcnt), 32'd0);
    chk("t1_ready_e5", 32'(bus.o_ready), 32'd0);
    edges(1);
    chk("t1_cnt_e6", 32'(xcnt), 32'd1);
    chk("t1_ready_e6", 32'(bus.o_ready), 32'd1);
    chk("t1_data_e6", 32'(bus.o_xfer_data), 32'hA5);

    // back-to-back words
    for (int i = 0; i < 4; i++) send(DW'($urandom), acc[i]);
    for (int i = 1; i < 4; i++) chk("b2b_interval", 32'(acc[i] - acc[i-1]), 32'(WORD_CYC));
    edges(WORD_CYC - 1);
    chk("b2b_cnt", 32'(xcnt), 32'd5);

    // stalled REQ phase -> timeout
    @(negedge clk);
    loop_en = 1'b0;
    ack_force = 1'b0;
    send(8'h5A, a0);
    edges(T - 1);
    chk("tmo_before", 32'(tmo), 32'd0);
    edges(1);
    chk("tmo_set", 32'(tmo), 32'd1);
    chk("tmo_req_held", 32'(bus.o_xfer_req), 32'd1);
    loop_en = 1'b1;
    wait_idle();
    chk("tmo_sticky", 32'(tmo), 32'd1);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    chk("tmo_cleared", 32'(tmo), 32'd0);

    // clear coincident with a new set: set wins
    @(negedge clk);
    loop_en = 1'b0;
    send(8'hC3, a0);
    edges(T - 1);
    clr_err = 1'b1;
    edges(1);
    chk("tmo_set_wins", 32'(tmo), 32'd1);
    edges(1);
    clr_err = 1'b0;
    chk("tmo_clr_after", 32'(tmo), 32'd0);
    loop_en = 1'b1;
    wait_idle();

    // stale ack held through reset release
    @(negedge clk);
    rst = 1'b1;
    loop_en = 1'b0;
    ack_force = 1'b1;
    bus.i_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("stale_ready_in_rst", 32'(bus.o_ready), 32'd1);
    chk("stale_busy_in_rst", 32'(busy), 32'd0);
    bus.i_valid = 1'b0;
    rst = 1'b0;
    edges(S);
    chk("stale_ready_low", 32'(bus.o_ready), 32'd0);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h77;
    edges(3);
    chk("stale_valid_ignored", 32'(busy), 32'd0);
    @(negedge clk);
    bus.i_valid = 1'b0;
    ack_force = 1'b0;
    edges(1);
    chk("stale_ready_e1", 32'(bus.o_ready), 32'd0);
    edges(1);
    chk("stale_ready_e2", 32'(bus.o_ready), 32'd1);

    // reset pulsed during REQ with ack high
    send(8'h96, a0);
    ack_force = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    edges(1);
    chk("midrst_req", 32'(bus.o_xfer_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cnt", 32'(xcnt), 32'd0);
    chk("midrst_data", 32'(bus.o_xfer_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    edges(S);
    chk("midrst_ready_blocked", 32'(bus.o_ready), 32'd0);
    @(negedge clk);
    ack_force = 1'b0;
    edges(S);
    chk("midrst_ready_back", 32'(bus.o_ready), 32'd1);
    @(negedge clk);
    loop_en = 1'b1;

    // transfer counter wrap
    @(negedge clk);
    force dut.r_xfer_cnt = 16'hFFFF;
    preload_req++;
    @(negedge clk);
    release dut.r_xfer_cnt;
    send(8'h3C, a0);
    wait_idle();
    chk("cnt_wrap", 32'(xcnt), 32'd0);

    // random words with random gaps
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      send(DW'($urandom), a0);
    end
    wait_idle();
    chk("no_dropped_words", 32'(exp_q.size()), 32'd0);
    chk("tmo_quiet_random", 32'(tmo), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
